// File: rtl/miter_mon_pkg.sv
// miter_mon_pkg: shared state encoding and saturating increment for the miter mismatch monitor
package miter_mon_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE = 2'd0, SETTLE = 2'd1, CHECK = 2'd2, FAILED = 2'd3} mon_state_e;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max;
    max = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return (v >= max) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/miter_mon_trace_ring.sv
// miter_mon_trace_ring: ring of the most recent failing diffs, oldest entry overwritten on wrap
module miter_mon_trace_ring #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wp] <= wdata;
      wp <= wp + AW'(1);
    end
  end
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/miter_mismatch_monitor.sv
// miter_mismatch_monitor: care-masked gold/gate compare with settle window, sticky fail and first-failure snapshot
// Optional failing-diff trace ring enabled by defining MITER_MON_TRACE_EN.
module miter_mismatch_monitor
  import miter_mon_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int CNT_W       = 16,
  parameter int SETTLE      = 4,
  parameter int TRACE_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   po_gold,
  input  logic [WIDTH-1:0]   po_gate,
  input  logic [WIDTH-1:0]   care,
  output logic [STATE_W-1:0] state,
  output logic               fail,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   first_cycle,
  output logic [WIDTH-1:0]   first_diff
`ifdef MITER_MON_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [WIDTH-1:0]               trace_rd_data
`endif
);
  mon_state_e st;
  logic [7:0] settle_cnt;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] diff;
  logic cmp, hit;
  assign diff = (po_gold ^ po_gate) & care;
  // arm and clear both pre-empt the sample presented with them
  assign cmp = in_valid && !clear && !arm && (st == CHECK || st == FAILED);
  assign hit = cmp && (diff != '0);
  assign state = st;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      st <= IDLE;
      fail <= 1'b0;
      mismatch_cnt <= '0;
      first_cycle <= '0;
      first_diff <= '0;
      settle_cnt <= '0;
      idx <= '0;
    end else if (arm) begin
      st <= (SETTLE == 0) ? CHECK : miter_mon_pkg::SETTLE;
      mismatch_cnt <= '0;
      first_cycle <= '0;
      first_diff <= '0;
      settle_cnt <= '0;
      idx <= '0;
    end else if (in_valid) begin
      if (st == miter_mon_pkg::SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
        if (settle_cnt == 8'(SETTLE - 1)) st <= CHECK;
      end
      if (cmp) idx <= CNT_W'(sat_inc(64'(idx), CNT_W));
      if (hit) begin
        fail <= 1'b1;
        mismatch_cnt <= CNT_W'(sat_inc(64'(mismatch_cnt), CNT_W));
        if (st == CHECK) begin
          st <= FAILED;
          first_cycle <= idx;
          first_diff <= diff;
        end
      end
    end
  end
`ifdef MITER_MON_TRACE_EN
  miter_mon_trace_ring #(.WIDTH(WIDTH), .DEPTH(TRACE_DEPTH)) u_trace (
    .clk(clk),
    .rst(rst),
    .clr(clear),
    .we(hit),
    .wdata(diff),
    .rd_idx(trace_rd_idx),
    .rd_data(trace_rd_data)
  );
`endif
endmodule

// File: tb/tb_miter_mismatch_monitor.sv
// tb_miter_mismatch_monitor: table-driven directed checks plus saturation, reset-collision and trace sequences
module tb_miter_mismatch_monitor;
  logic clk = 1'b0, rst = 1'b1, arm = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [7:0] po_gold = '0, po_gate = '0, care = '0;
  logic [1:0] state;
  logic fail;
  logic [3:0] mismatch_cnt, first_cycle;
  logic [7:0] first_diff;
`ifdef MITER_MON_TRACE_EN
  logic [2:0] trace_rd_idx = '0;
  logic [7:0] trace_rd_data;
`endif
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  miter_mismatch_monitor #(.WIDTH(8), .CNT_W(4), .SETTLE(4), .TRACE_DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .clear(clear),
    .in_valid(in_valid),
    .po_gold(po_gold),
    .po_gate(po_gate),
    .care(care),
    .state(state),
    .fail(fail),
    .mismatch_cnt(mismatch_cnt),
    .first_cycle(first_cycle),
    .first_diff(first_diff)
`ifdef MITER_MON_TRACE_EN
    ,
    .trace_rd_idx(trace_rd_idx),
    .trace_rd_data(trace_rd_data)
`endif
  );

  typedef struct {
    logic a, c, v;
    logic [7:0] gold, gate, cr;
    logic [1:0] st;
    logic fl;
    logic [3:0] cnt, fc;
    logic [7:0] fd;
  } vec_t;
  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic c, input logic v, input logic [7:0] g, input logic [7:0] t, input logic [7:0] cr);
    arm = a; clear = c; in_valid = v; po_gold = g; po_gate = t; care = cr;
    @(negedge clk);
    arm = 1'b0; clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic fl, input logic [3:0] cnt, input logic [3:0] fc, input logic [7:0] fd);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".fail"}, 32'(fail), 32'(fl));
    chk({tag, ".cnt"}, 32'(mismatch_cnt), 32'(cnt));
    chk({tag, ".first_cycle"}, 32'(first_cycle), 32'(fc));
    chk({tag, ".first_diff"}, 32'(first_diff), 32'(fd));
  endtask

  initial begin
    vecs[0]  = '{0,0,1,8'h01,8'h00,8'h01, 2'd0,0,4'd0,4'd0,8'h00};
    vecs[1]  = '{1,0,0,8'h00,8'h00,8'h00, 2'd1,0,4'd0,4'd0,8'h00};
    vecs[2]  = '{0,0,1,8'h01,8'h00,8'h01, 2'd1,0,4'd0,4'd0,8'h00};
    vecs[3]  = '{0,0,1,8'h01,8'h00,8'h01, 2'd1,0,4'd0,4'd0,8'h00};
    vecs[4]  = '{0,0,1,8'h01,8'h00,8'h01, 2'd1,0,4'd0,4'd0,8'h00};
    vecs[5]  = '{0,0,1,8'h01,8'h00,8'h01, 2'd2,0,4'd0,4'd0,8'h00};
    vecs[6]  = '{0,0,0,8'h01,8'h00,8'h01, 2'd2,0,4'd0,4'd0,8'h00};
    vecs[7]  = '{0,0,1,8'h01,8'h00,8'h01, 2'd3,1,4'd1,4'd0,8'h01};
    vecs[8]  = '{1,0,0,8'h00,8'h00,8'h00, 2'd1,1,4'd0,4'd0,8'h00};
    vecs[9]  = '{0,1,0,8'h00,8'h00,8'h00, 2'd0,0,4'd0,4'd0,8'h00};
    vecs[10] = '{1,0,1,8'h01,8'h00,8'h01, 2'd1,0,4'd0,4'd0,8'h00};
    vecs[11] = '{0,0,1,8'hA5,8'hA5,8'hFF, 2'd1,0,4'd0,4'd0,8'h00};
    vecs[12] = '{0,0,1,8'hA5,8'hA5,8'hFF, 2'd1,0,4'd0,4'd0,8'h00};
    vecs[13] = '{0,0,1,8'hA5,8'hA5,8'hFF, 2'd1,0,4'd0,4'd0,8'h00};
    vecs[14] = '{0,0,1,8'hA5,8'hA5,8'hFF, 2'd2,0,4'd0,4'd0,8'h00};
    vecs[15] = '{0,0,1,8'hA5,8'hA5,8'hFF, 2'd2,0,4'd0,4'd0,8'h00};
    vecs[16] = '{0,0,1,8'hA5,8'hA4,8'hFE, 2'd2,0,4'd0,4'd0,8'h00};
    vecs[17] = '{0,0,1,8'hA5,8'hA5,8'hFF, 2'd2,0,4'd0,4'd0,8'h00};
    vecs[18] = '{0,0,1,8'hA5,8'hA4,8'hFF, 2'd3,1,4'd1,4'd3,8'h01};
    vecs[19] = '{0,0,1,8'hF0,8'h00,8'hFF, 2'd3,1,4'd2,4'd3,8'h01};
    vecs[20] = '{0,0,0,8'hF0,8'h00,8'hFF, 2'd3,1,4'd2,4'd3,8'h01};
    vecs[21] = '{0,1,1,8'hF0,8'h00,8'hFF, 2'd0,0,4'd0,4'd0,8'h00};
    vecs[22] = '{0,0,1,8'hF0,8'h00,8'hFF, 2'd0,0,4'd0,4'd0,8'h00};
    vecs[23] = '{1,0,0,8'h00,8'h00,8'h00, 2'd1,0,4'd0,4'd0,8'h00};
    repeat (2) @(negedge clk);
    chk_all("reset", 2'd0, 1'b0, 4'd0, 4'd0, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].a, vecs[i].c, vecs[i].v, vecs[i].gold, vecs[i].gate, vecs[i].cr);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].cnt, vecs[i].fc, vecs[i].fd);
    end
    // armed by vec23: settle, an all-zero care sample at index 0, then 20 failures
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'h11, 8'h11, 8'hFF);
    drive(0, 0, 1, 8'hFF, 8'h00, 8'h00);
    chk_all("care0", 2'd2, 1'b0, 4'd0, 4'd0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 8'h0F, 8'h00, 8'hFF);
      chk($sformatf("sat%0d.cnt", i), 32'(mismatch_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    chk_all("sat_end", 2'd3, 1'b1, 4'd15, 4'd1, 8'h0F);
    rst = 1'b1;
    drive(0, 0, 1, 8'h0F, 8'h00, 8'hFF);
    chk_all("rst_hit", 2'd0, 1'b0, 4'd0, 4'd0, 8'h00);
    rst = 1'b0;
`ifdef MITER_MON_TRACE_EN
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'h00, 8'h00, 8'hFF);
    for (int i = 1; i <= 10; i++) drive(0, 0, 1, 8'(i), 8'h00, 8'hFF);
    chk("trace.cnt", 32'(mismatch_cnt), 32'd10);
    for (int i = 0; i < 8; i++) begin
      trace_rd_idx = 3'(i);
      #1;
      chk($sformatf("trace%0d", i), 32'(trace_rd_data), (i < 2) ? 32'(i + 9) : 32'(i + 1));
    end
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00);
    trace_rd_idx = 3'd0;
    #1;
    chk("trace_clear", 32'(trace_rd_data), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
